// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator scheduler.
// State encoding, sweep direction constants and floor decode.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE   = 2'd1,
      ARRIVE = 2'd2,
      DOOR   = 2'd3
   } state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam int MAX_FLOORS = 32;
   localparam int IDX_W      = 5;

   // Decode a floor index into a one-hot floor mask.
   function automatic logic [MAX_FLOORS-1:0] onehot(input logic [IDX_W-1:0] f);
      logic [MAX_FLOORS-1:0] m;
      m    = '0;
      m[f] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/elevator_scheduler_door_timer.sv
// Door dwell timer: loads, reloads on hold, counts down.
// o_expired marks the final cycle of the dwell window.
module door_timer #(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_dec,
   output logic o_expired
);

   localparam int W = $clog2(CYCLES + 1);

   logic [W-1:0] r_count;

   // Counter: load wins over decrement; stops at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= W'(CYCLES);
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_expired = (r_count <= W'(1));

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: SCAN request selection plus
// motion and door sequencing, all outputs registered.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int N_FLOORS    = 4,
   parameter int FLOOR_W     = 2,
   parameter int DOOR_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_FLOORS-1:0] floor_req,
   input  logic [FLOOR_W-1:0]  current_floor,
   input  logic                floor_valid,
   input  logic                door_hold,
   output logic                motor_up,
   output logic                motor_down,
   output logic                door_open,
   output logic                direction,
   output logic [N_FLOORS-1:0] pending,
   output logic                busy
);

   localparam logic [FLOOR_W:0] NF = (FLOOR_W + 1)'(N_FLOORS);

   state_t              r_state;
   logic [N_FLOORS-1:0] r_pending;
   logic                r_dir;
   logic                r_motor_up;
   logic                r_motor_dn;
   logic                r_door;
   logic                r_busy;

   state_t              w_next;
   logic                w_dir_nxt;
   logic                w_load;
   logic                w_dec;
   logic                w_expired;
   logic                w_fv;
   logic [N_FLOORS-1:0] w_oh;
   logic [N_FLOORS-1:0] w_below_m;
   logic [N_FLOORS-1:0] w_above_m;
   logic [N_FLOORS-1:0] w_clr;
   logic                w_above;
   logic                w_below;
   logic                w_here;
   logic                w_ahead;
   logic                w_scan_dir;

   assign w_fv      = floor_valid && ({1'b0, current_floor} < NF);
   assign w_oh      = N_FLOORS'(onehot(IDX_W'(current_floor)));
   assign w_below_m = w_oh - N_FLOORS'(1);
   assign w_above_m = ~(w_below_m | w_oh);
   assign w_above   = |(r_pending & w_above_m);
   assign w_below   = |(r_pending & w_below_m);
   assign w_here    = |(r_pending & w_oh);
   assign w_ahead   = r_dir ? w_above : w_below;
   assign w_scan_dir = (w_above && (r_dir || !w_below)) ? DIR_UP : DIR_DN;
   assign w_clr     = ((w_next == DOOR) || (r_state == DOOR)) ? w_oh : '0;

   door_timer #(
      .CYCLES(DOOR_CYCLES)
   ) u_door_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_dec    (w_dec),
      .o_expired(w_expired)
   );

   // Next-state, sweep direction and door timer control.
   always_comb begin
      w_next    = r_state;
      w_dir_nxt = r_dir;
      w_load    = 1'b0;
      w_dec     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_fv && w_here) begin
               w_next = DOOR;
            end else if (w_above || w_below) begin
               w_next    = MOVE;
               w_dir_nxt = w_scan_dir;
            end
         end
         MOVE: begin
            if (w_fv && (w_here || !w_ahead)) begin
               w_next = ARRIVE;
            end
         end
         ARRIVE: begin
            w_next = DOOR;
         end
         DOOR: begin
            if (door_hold) begin
               w_load = 1'b1;
            end else begin
               w_dec = 1'b1;
               if (w_expired) begin
                  if (w_above || w_below) begin
                     w_next    = MOVE;
                     w_dir_nxt = w_scan_dir;
                  end else begin
                     w_next = IDLE;
                  end
               end
            end
         end
         default: w_next = IDLE;
      endcase
      if ((w_next == DOOR) && (r_state != DOOR)) begin
         w_load = 1'b1;
      end
   end

   // State, request latch and registered actuator outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_pending  <= '0;
         r_dir      <= DIR_UP;
         r_motor_up <= 1'b0;
         r_motor_dn <= 1'b0;
         r_door     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_pending  <= (r_pending | floor_req) & ~w_clr;
         r_dir      <= w_dir_nxt;
         r_motor_up <= (w_next == MOVE) && w_dir_nxt;
         r_motor_dn <= (w_next == MOVE) && !w_dir_nxt;
         r_door     <= (w_next == DOOR);
         r_busy     <= (w_next != IDLE);
      end
   end

   assign motor_up   = r_motor_up;
   assign motor_down = r_motor_dn;
   assign door_open  = r_door;
   assign direction  = r_dir;
   assign pending    = r_pending;
   assign busy       = r_busy;

   a_one_motor : assert property (@(posedge clk) disable iff (rst)
      !(motor_up && motor_down));
   a_door_motor : assert property (@(posedge clk) disable iff (rst)
      !(door_open && (motor_up || motor_down)));
   a_door_level : assert property (@(posedge clk) disable iff (rst)
      ((w_next == DOOR) && (r_state != DOOR)) |-> w_fv);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: vector table
// plus hand sequences for reset and door hold.
module tb_elevator_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] floor_req = '0;
   logic [1:0] current_floor = '0;
   logic       floor_valid = 1'b0;
   logic       door_hold = 1'b0;
   logic       motor_up;
   logic       motor_down;
   logic       door_open;
   logic       direction;
   logic [3:0] pending;
   logic       busy;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] req;
      logic [1:0] cf;
      logic       fv;
      logic [8:0] exp;
   } vec_t;

   vec_t tv[$];

   elevator_scheduler #(
      .N_FLOORS(4),
      .FLOOR_W(2),
      .DOOR_CYCLES(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .floor_req    (floor_req),
      .current_floor(current_floor),
      .floor_valid  (floor_valid),
      .door_hold    (door_hold),
      .motor_up     (motor_up),
      .motor_down   (motor_down),
      .door_open    (door_open),
      .direction    (direction),
      .pending      (pending),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Expected bundle: {up, down, door, dir, busy, pending}.
   function automatic logic [8:0] bund(input logic mu, input logic md,
                                       input logic dr, input logic di,
                                       input logic bz, input logic [3:0] p);
      return {mu, md, dr, di, bz, p};
   endfunction

   task automatic add(input logic [3:0] rq, input int c, input logic v,
                      input logic mu, input logic md, input logic dr,
                      input logic di, input logic bz, input logic [3:0] p);
      vec_t t;
      t.req = rq;
      t.cf  = 2'(c);
      t.fv  = v;
      t.exp = bund(mu, md, dr, di, bz, p);
      tv.push_back(t);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [8:0] exp);
      logic [8:0] act;
      act = {motor_up, motor_down, door_open, direction, busy, pending};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got up/dn/door/dir/busy/pend=%b wanted %b",
                  name, act, exp);
      end
   endtask

   initial begin
      // floor 0 -> 2 trip
      add(4'b0100, 0, 1, 0, 0, 0, 1, 0, 4'b0100);
      add(4'b0000, 0, 1, 1, 0, 0, 1, 1, 4'b0100);
      add(4'b0000, 1, 1, 1, 0, 0, 1, 1, 4'b0100);
      add(4'b0000, 2, 1, 0, 0, 0, 1, 1, 4'b0100);
      add(4'b0000, 2, 1, 0, 0, 1, 1, 1, 4'b0000);
      add(4'b0000, 2, 1, 0, 0, 1, 1, 1, 4'b0000);
      add(4'b0000, 2, 1, 0, 0, 1, 1, 1, 4'b0000);
      add(4'b0000, 2, 1, 0, 0, 1, 1, 1, 4'b0000);
      add(4'b0000, 2, 1, 0, 0, 0, 1, 0, 4'b0000);
      // floor 2 -> 0, pass floor 1
      add(4'b0001, 2, 1, 0, 0, 0, 1, 0, 4'b0001);
      add(4'b0000, 2, 1, 0, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 1, 1, 0, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 1, 0, 0, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 0, 1, 0, 0, 0, 0, 1, 4'b0001);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
      // up to 2 with a late call at 0: serve 2, then reverse
      add(4'b0100, 0, 1, 0, 0, 0, 0, 0, 4'b0100);
      add(4'b0000, 0, 1, 1, 0, 0, 1, 1, 4'b0100);
      add(4'b0001, 0, 0, 1, 0, 0, 1, 1, 4'b0101);
      add(4'b0000, 1, 1, 1, 0, 0, 1, 1, 4'b0101);
      add(4'b0000, 2, 1, 0, 0, 0, 1, 1, 4'b0101);
      add(4'b0000, 2, 1, 0, 0, 1, 1, 1, 4'b0001);
      add(4'b0000, 2, 1, 0, 0, 1, 1, 1, 4'b0001);
      add(4'b0000, 2, 1, 0, 0, 1, 1, 1, 4'b0001);
      add(4'b0000, 2, 1, 0, 0, 1, 1, 1, 4'b0001);
      add(4'b0000, 2, 1, 0, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 1, 1, 0, 1, 0, 0, 1, 4'b0001);
      add(4'b0000, 0, 1, 0, 0, 0, 0, 1, 4'b0001);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
      // call at current floor, repeated during door
      add(4'b0001, 0, 1, 0, 0, 0, 0, 0, 4'b0001);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0001, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 1, 0, 1, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
      add(4'b0000, 0, 1, 0, 0, 0, 0, 0, 4'b0000);

      // reset state
      step();
      check("reset", bund(0, 0, 0, 1, 0, 4'b0000));
      rst = 1'b0;

      foreach (tv[i]) begin
         floor_req     = tv[i].req;
         current_floor = tv[i].cf;
         floor_valid   = tv[i].fv;
         step();
         check($sformatf("vec%0d", i), tv[i].exp);
      end

      // reset while moving down
      floor_req     = 4'b0001;
      current_floor = 2'd3;
      floor_valid   = 1'b1;
      step();
      check("mm_latch", bund(0, 0, 0, 0, 0, 4'b0001));
      floor_req = 4'b0000;
      step();
      check("mm_move", bund(0, 1, 0, 0, 1, 4'b0001));
      #2 rst = 1'b1;
      #1 check("mm_async_rst", bund(0, 0, 0, 1, 0, 4'b0000));
      step();
      rst = 1'b0;
      step();
      check("mm_after_rst", bund(0, 0, 0, 1, 0, 4'b0000));

      // door hold with sensor glitch
      floor_req = 4'b1000;
      step();
      check("hold_latch", bund(0, 0, 0, 1, 0, 4'b1000));
      floor_req = 4'b0000;
      step();
      check("hold_open", bund(0, 0, 1, 1, 1, 4'b0000));
      door_hold = 1'b1;
      for (int k = 0; k < 10; k++) begin
         floor_valid = !(k == 4 || k == 5);
         step();
         check($sformatf("hold%0d", k), bund(0, 0, 1, 1, 1, 4'b0000));
      end
      door_hold   = 1'b0;
      floor_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("release%0d", k), bund(0, 0, 1, 1, 1, 4'b0000));
      end
      step();
      check("hold_close", bund(0, 0, 0, 1, 0, 4'b0000));

      // reset while door open
      floor_req     = 4'b0010;
      current_floor = 2'd1;
      step();
      check("md_latch", bund(0, 0, 0, 1, 0, 4'b0010));
      floor_req = 4'b0000;
      step();
      check("md_open", bund(0, 0, 1, 1, 1, 4'b0000));
      floor_req = 4'b0100;
      step();
      check("md_req", bund(0, 0, 1, 1, 1, 4'b0100));
      #2 rst = 1'b1;
      #1 check("md_async_rst", bund(0, 0, 0, 1, 0, 4'b0000));
      floor_req = 4'b0000;
      step();
      rst = 1'b0;
      step();
      check("md_after_rst", bund(0, 0, 0, 1, 0, 4'b0000));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
